// File: rtl/conv3x3_filter_pkg.sv
// Shared widths, tap indices and the identity-kernel reset value for the 3x3 convolution stage.
package conv_pkg;

  localparam int PIXEL_W    = 8;
  localparam int COEF_W     = 8;
  localparam int ACC_W      = 21;
  localparam int NUM_TAPS   = 9;
  localparam int CENTER_TAP = 4;
  localparam int NORM_IDX   = 9;
  localparam int SHIFT_W    = 4;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic [NUM_TAPS-1:0][COEF_W-1:0] kernel_t;

  // Only the centre tap is 1, so the filter passes pixel_5 straight through.
  localparam kernel_t IDENTITY_KERNEL = kernel_t'(1) << (CENTER_TAP * COEF_W);

endpackage

// File: rtl/conv3x3_filter_mac_row.sv
// One kernel row: three pixel*coefficient multipliers (stage 1) feeding a registered row adder (stage 2).
module conv_mac_row
  import conv_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_enable,
  input  logic [2:0][PIXEL_W-1:0]           i_pixels,
  input  coef_t [2:0]                       i_coefs,
  output logic signed [PIXEL_W+COEF_W+2:0]  o_row_sum
);

  localparam int PROD_W = PIXEL_W + 1 + COEF_W;
  localparam int ROW_W  = PROD_W + 2;

  logic signed [PROD_W-1:0] w_prod [3];
  logic signed [PROD_W-1:0] r_prod [3];
  logic signed [ROW_W-1:0]  r_row_sum;

  // Pixels are unsigned, so a zero bit is prepended before the signed multiply.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_prod[i] = PROD_W'($signed({1'b0, i_pixels[i]})) * PROD_W'($signed(i_coefs[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        r_prod[i] <= '0;
      end
      r_row_sum <= '0;
    end else if (i_enable) begin
      for (int i = 0; i < 3; i++) begin
        r_prod[i] <= w_prod[i];
      end
      r_row_sum <= ROW_W'(r_prod[0]) + ROW_W'(r_prod[1]) + ROW_W'(r_prod[2]);
    end
  end

  assign o_row_sum = r_row_sum;

endmodule

// File: rtl/conv3x3_filter.sv
// Three-stage 3x3 convolution with a programmable kernel, normalising shift, clamp and output counter.
// Define CONV3X3_ABS_EN to fold negative sums to their magnitude instead of clamping them to zero.
module conv3x3_filter #(
  parameter int PIXEL_W = conv_pkg::PIXEL_W,
  parameter int COEF_W  = conv_pkg::COEF_W,
  parameter int CNT_W   = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_start,
  input  logic               window_valid,
  input  logic [PIXEL_W-1:0] pixel_1,
  input  logic [PIXEL_W-1:0] pixel_2,
  input  logic [PIXEL_W-1:0] pixel_3,
  input  logic [PIXEL_W-1:0] pixel_4,
  input  logic [PIXEL_W-1:0] pixel_5,
  input  logic [PIXEL_W-1:0] pixel_6,
  input  logic [PIXEL_W-1:0] pixel_7,
  input  logic [PIXEL_W-1:0] pixel_8,
  input  logic [PIXEL_W-1:0] pixel_9,
  input  logic               coef_we,
  input  logic [3:0]         coef_idx,
  input  logic [COEF_W-1:0]  coef_data,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               pixel_valid,
  output logic [CNT_W-1:0]   out_count
);

  import conv_pkg::*;

  localparam int ROW_W = PIXEL_W + COEF_W + 3;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIXEL_W) - 1);

  kernel_t                          r_coef;
  logic [SHIFT_W-1:0]               r_shift;
  logic [SHIFT_W-1:0]               r_shift_s1;
  logic [SHIFT_W-1:0]               r_shift_s2;
  logic                             r_valid_s1;
  logic                             r_valid_s2;
  logic                             r_valid_s3;
  logic [PIXEL_W-1:0]               r_pixel_out;
  logic [CNT_W-1:0]                 r_out_count;
  logic [NUM_TAPS-1:0][PIXEL_W-1:0] w_window;
  logic signed [ROW_W-1:0]          w_row_sum [3];
  logic signed [ACC_W-1:0]          w_sum;
  logic signed [ACC_W-1:0]          w_shifted;
  logic signed [ACC_W-1:0]          w_mag;
  logic [PIXEL_W-1:0]               w_clamped;

  assign w_window = {pixel_9, pixel_8, pixel_7, pixel_6, pixel_5,
                     pixel_4, pixel_3, pixel_2, pixel_1};

  // Coefficient file ignores enable so software can reprogram a stalled pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coef  <= IDENTITY_KERNEL;
      r_shift <= '0;
    end else if (coef_we) begin
      if (coef_idx < 4'(NORM_IDX)) begin
        r_coef[coef_idx] <= coef_data;
      end else if (coef_idx == 4'(NORM_IDX)) begin
        r_shift <= coef_data[SHIFT_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_row
    conv_mac_row u_row (
      .clk       (clk),
      .reset     (reset),
      .i_enable  (enable),
      .i_pixels  (w_window[3*g+2:3*g]),
      .i_coefs   (r_coef[3*g+2:3*g]),
      .o_row_sum (w_row_sum[g])
    );
  end

  always_comb begin
    w_sum     = ACC_W'(w_row_sum[0]) + ACC_W'(w_row_sum[1]) + ACC_W'(w_row_sum[2]);
    w_shifted = w_sum >>> r_shift_s2;
    w_mag     = w_shifted;
`ifdef CONV3X3_ABS_EN
    if (w_shifted < 0) begin
      w_mag = -w_shifted;
    end
`endif
    if (w_mag < 0) begin
      w_clamped = '0;
    end else if (w_mag > PIX_MAX) begin
      w_clamped = '1;
    end else begin
      w_clamped = w_mag[PIXEL_W-1:0];
    end
  end

  // The shift travels with its window so a mid-stream rewrite only affects later windows.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_s1  <= 1'b0;
      r_valid_s2  <= 1'b0;
      r_valid_s3  <= 1'b0;
      r_shift_s1  <= '0;
      r_shift_s2  <= '0;
      r_pixel_out <= '0;
    end else begin
      if (enable) begin
        r_valid_s1  <= window_valid;
        r_valid_s2  <= r_valid_s1;
        r_valid_s3  <= r_valid_s2;
        r_shift_s1  <= r_shift;
        r_shift_s2  <= r_shift_s1;
        r_pixel_out <= w_clamped;
      end
      if (frame_start) begin
        r_valid_s2 <= 1'b0;
        r_valid_s3 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      r_out_count <= '0;
    end else if (enable && r_valid_s3) begin
      r_out_count <= r_out_count + 1'b1;
    end
  end

  assign pixel_out   = r_pixel_out;
  assign pixel_valid = r_valid_s3;
  assign out_count   = r_out_count;

endmodule
